// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble converter: unsigned binary in, packed BCD out, one input bit per clock.
// A sticky flag records any carry lost off the top digit so the caller knows the result wrapped.
module bin_to_bcd_serial #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_Start,
    input  logic [WIDTH-1:0]      i_Bin,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic [4*DIGITS-1:0]   o_BCD,
    output logic                  o_Overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    // Add 3 to every digit that would reach 10 or more once doubled.
    function automatic logic [BW-1:0] adjust(input logic [BW-1:0] s);
        logic [BW-1:0] r;
        r = s;
        for (int d = 0; d < DIGITS; d++) begin
            if (s[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = s[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    state_t          state;
    logic [WIDTH-1:0] shift_reg;
    logic [BW-1:0]   scratch;
    logic            sticky;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   adj;

    assign adj = adjust(scratch);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state      <= IDLE;
            shift_reg  <= '0;
            scratch    <= '0;
            sticky     <= 1'b0;
            cnt        <= '0;
            o_Busy     <= 1'b0;
            o_Done     <= 1'b0;
            o_BCD      <= '0;
            o_Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_Done <= 1'b0;
                    if (i_Start) begin
                        shift_reg <= i_Bin;
                        scratch   <= '0;
                        sticky    <= 1'b0;
                        cnt       <= CW'(WIDTH);
                        o_Busy    <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    o_Done    <= 1'b0;
                    // The adjusted top bit falls off the scratch and is only remembered as overflow.
                    scratch   <= {adj[BW-2:0], shift_reg[WIDTH-1]};
                    shift_reg <= shift_reg << 1;
                    sticky    <= sticky | adj[BW-1];
                    cnt       <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    o_BCD      <= scratch;
                    o_Overflow <= sticky;
                    o_Done     <= 1'b1;
                    o_Busy     <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    o_Done <= 1'b0;
                    o_Busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
